seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the BCD-to-7-segment encoder. It monitors a multiplexed, active-low 7-segment display bus: one-hot-low digit enables plus the shared segment lines.
- It reconstructs the BCD value of each scanned digit and flags blank or illegal patterns.
- It is used for display loop-back self-test and for probing an external clock-display board.
- Segment format is abcdefg with bit6 = a and bit0 = g, active-low, matching the encoder.

---
 rtl/seg_scan_decoder.sv | 124 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side 7-segment scan monitor: watches a multiplexed active-low
// display bus and rebuilds per-digit BCD values with blank/illegal flags.
module seg_scan_decoder #(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_DIGITS-1:0]   an_i,
  input  logic [6:0]            seg_i,
  output logic [4*N_DIGITS-1:0] digits_o,
  output logic [N_DIGITS-1:0]   blank_o,
  output logic [N_DIGITS-1:0]   err_o,
  output logic                  upd_valid_o,
  output logic [IDX_W-1:0]      upd_idx_o,
  output logic                  all_seen_o
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [N_DIGITS-1:0] smp_an;
  logic [6:0]          smp_seg;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                acc;
  logic                acc_nxt;
  logic                in_valid;
  logic                in_same;
  logic [N_DIGITS-1:0] seen;
  logic [N_DIGITS-1:0] slot_oh;
  logic [IDX_W-1:0]    slot_idx;
  logic [3:0]          dec_digit;
  logic                dec_blank;
  logic                dec_err;

  // Stability tracking on the sample being captured versus the one held.
  always_comb begin
    cnt_nxt  = '0;
    acc_nxt  = 1'b0;
    in_valid = $onehot(~an_i);
    in_same  = (an_i == smp_an) && (seg_i == smp_seg);
    if (in_valid) begin
      if (!in_same) begin
        cnt_nxt = CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        cnt_nxt = cnt;
      end
      // Fire only on the step into saturation so a held pattern pulses once.
      acc_nxt = (cnt_nxt == CNT_MAX) && (!in_same || (cnt != CNT_MAX));
    end
  end

  // Decode of the held segment pattern into {digit, blank, err}.
  always_comb begin
    dec_digit = 4'hE;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    unique case (smp_seg)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      7'b1111111: begin
        dec_digit = 4'hF;
        dec_blank = 1'b1;
      end
      default:    dec_err = 1'b1;
    endcase
  end

  // Slot addressed by the held sample; one-hot when an accept is pending.
  always_comb begin
    slot_oh  = ~smp_an;
    slot_idx = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (!smp_an[k]) slot_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_an      <= '0;
      smp_seg     <= '0;
      cnt         <= '0;
      acc         <= 1'b0;
      seen        <= '0;
      digits_o    <= '1;
      blank_o     <= '1;
      err_o       <= '0;
      upd_valid_o <= 1'b0;
      upd_idx_o   <= '0;
      all_seen_o  <= 1'b0;
    end else begin
      smp_an      <= an_i;
      smp_seg     <= seg_i;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      upd_valid_o <= acc;
      if (acc) begin
        upd_idx_o  <= slot_idx;
        seen       <= seen | slot_oh;
        all_seen_o <= all_seen_o | (&(seen | slot_oh));
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
          if (slot_oh[k]) begin
            digits_o[4*k +: 4] <= dec_digit;
            blank_o[k]         <= dec_blank;
            err_o[k]           <= dec_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed vector bench for seg_scan_decoder (N_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_decoder;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  an_i;
  logic [6:0]  seg_i;
  logic [15:0] digits_o;
  logic [3:0]  blank_o;
  logic [3:0]  err_o;
  logic        upd_valid_o;
  logic [1:0]  upd_idx_o;
  logic        all_seen_o;

  int n_chk;
  int n_fail;

  seg_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .an_i        (an_i),
    .seg_i       (seg_i),
    .digits_o    (digits_o),
    .blank_o     (blank_o),
    .err_o       (err_o),
    .upd_valid_o (upd_valid_o),
    .upd_idx_o   (upd_idx_o),
    .all_seen_o  (all_seen_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          pulses;
    logic [1:0]  idx;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        seen;
  } row_t;

  row_t rows[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " digits"},    32'(digits_o),    32'hFFFF);
    chk({tag, " blank"},     32'(blank_o),     32'hF);
    chk({tag, " err"},       32'(err_o),       32'h0);
    chk({tag, " upd_valid"}, 32'(upd_valid_o), 32'h0);
    chk({tag, " upd_idx"},   32'(upd_idx_o),   32'h0);
    chk({tag, " all_seen"},  32'(all_seen_o),  32'h0);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_reset();
    rst_ni = 1'b0;
    an_i   = 4'b1111;
    seg_i  = 7'b1111111;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check_reset_values("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_row(input int r, input row_t v);
    int pulses;
    int first;
    logic [1:0] idx;
    pulses = 0;
    first  = 0;
    idx    = '0;
    an_i   = v.an;
    seg_i  = v.seg;
    for (int c = 1; c <= v.hold; c++) begin
      @(posedge clk_i);
      #1;
      if (upd_valid_o) begin
        pulses++;
        if (first == 0) first = c;
        idx = upd_idx_o;
      end
    end
    chk($sformatf("row%0d pulses", r), 32'(pulses), 32'(v.pulses));
    if (v.pulses > 0) begin
      chk($sformatf("row%0d upd_idx", r), 32'(idx), 32'(v.idx));
      chk($sformatf("row%0d latency", r), 32'(first), 32'd5);
    end
    chk($sformatf("row%0d digits", r),   32'(digits_o),   32'(v.digits));
    chk($sformatf("row%0d blank", r),    32'(blank_o),    32'(v.blank));
    chk($sformatf("row%0d err", r),      32'(err_o),      32'(v.err));
    chk($sformatf("row%0d all_seen", r), 32'(all_seen_o), 32'(v.seen));
  endtask

  initial begin
    int pulses;
    int first;
    n_chk  = 0;
    n_fail = 0;
    rst_ni = 1'b0;
    an_i   = 4'b1111;
    seg_i  = 7'b1111111;

    //          rst   an       seg          hold pul idx digits    blank    err      seen
    rows[0]  = '{1'b1, 4'b1110, 7'b0010010, 6,  1,  0, 16'hFFF2, 4'b1110, 4'b0000, 1'b0};
    rows[1]  = '{1'b0, 4'b1100, 7'b0000001, 10, 0,  0, 16'hFFF2, 4'b1110, 4'b0000, 1'b0};
    rows[2]  = '{1'b0, 4'b1101, 7'b0000110, 3,  0,  0, 16'hFFF2, 4'b1110, 4'b0000, 1'b0};
    rows[3]  = '{1'b0, 4'b1111, 7'b1111111, 2,  0,  0, 16'hFFF2, 4'b1110, 4'b0000, 1'b0};
    rows[4]  = '{1'b0, 4'b1101, 7'b0000110, 6,  1,  1, 16'hFF32, 4'b1100, 4'b0000, 1'b0};
    rows[5]  = '{1'b0, 4'b1101, 7'b0001111, 6,  1,  1, 16'hFF72, 4'b1100, 4'b0000, 1'b0};
    rows[6]  = '{1'b0, 4'b1011, 7'b1111111, 6,  1,  2, 16'hFF72, 4'b1100, 4'b0000, 1'b0};
    rows[7]  = '{1'b0, 4'b1011, 7'b1010101, 6,  1,  2, 16'hFE72, 4'b1000, 4'b0100, 1'b0};
    rows[8]  = '{1'b0, 4'b0111, 7'b0000000, 6,  1,  3, 16'h8E72, 4'b0000, 4'b0100, 1'b1};
    rows[9]  = '{1'b1, 4'b1110, 7'b1001111, 5,  1,  0, 16'hFFF1, 4'b1110, 4'b0000, 1'b0};
    rows[10] = '{1'b0, 4'b1101, 7'b0010010, 5,  1,  1, 16'hFF21, 4'b1100, 4'b0000, 1'b0};
    rows[11] = '{1'b0, 4'b1011, 7'b0100100, 5,  1,  2, 16'hF521, 4'b1000, 4'b0000, 1'b0};
    rows[12] = '{1'b0, 4'b0111, 7'b0000100, 5,  1,  3, 16'h9521, 4'b0000, 4'b0000, 1'b1};

    @(posedge clk_i);
    #1;
    for (int r = 0; r < 13; r++) begin
      if (rows[r].rst) do_reset();
      apply_row(r, rows[r]);
    end

    // Asynchronous reset in the middle of a count, away from any edge.
    an_i  = 4'b1110;
    seg_i = 7'b0000001;
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async");

    // Counting restarts from the first valid sample after release.
    @(negedge clk_i);
    rst_ni = 1'b1;
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk_i);
      #1;
      if (upd_valid_o) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("post-reset pulses",   32'(pulses),     32'd1);
    chk("post-reset latency",  32'(first),      32'd5);
    chk("post-reset digits",   32'(digits_o),   32'hFFF0);
    chk("post-reset blank",    32'(blank_o),    32'hE);
    chk("post-reset all_seen", 32'(all_seen_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
